// File: rtl/axi4_stream_downsizer_pkg.sv
// Shared constants and elaboration helpers for the AXI4-Stream width downsizer.
package axi4_stream_downsizer_pkg;

    localparam int DEF_DATA_SIZE    = 32;
    localparam int DEF_OUT_SIZE     = 8;
    localparam int DEF_PACKET_BEATS = 16;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int ratio_of(input int data_size, input int out_size);
        return data_size / out_size;
    endfunction

endpackage

// File: rtl/axi4_stream_downsizer_wrap_counter.sv
// Enabled up-counter over [0, MAX] that wraps to zero; at_max flags the final value.
module stream_wrap_counter
    import axi4_stream_downsizer_pkg::*;
#(
    parameter int MAX = 3,
    localparam int W  = clog2_min1(MAX + 1)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         at_max
);

    assign at_max = (count == W'(MAX));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (en) begin
            if (at_max) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_stream_downsizer.sv
// Splits wide stream words into narrow beats, LSB slice first, and frames
// fixed-length packets of output beats with write_data_last.
module axi4_stream_downsizer
    import axi4_stream_downsizer_pkg::*;
#(
    parameter int DATA_SIZE    = DEF_DATA_SIZE,
    parameter int OUT_SIZE     = DEF_OUT_SIZE,
    parameter int PACKET_BEATS = DEF_PACKET_BEATS
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [DATA_SIZE-1:0] read_data,
    input  logic                 read_data_valid,
    output logic                 read_data_ready,
    output logic [OUT_SIZE-1:0]  write_data,
    output logic                 write_data_valid,
    output logic                 write_data_last,
    input  logic                 write_data_ready
);

    localparam int RATIO = ratio_of(DATA_SIZE, OUT_SIZE);
    localparam int SW    = clog2_min1(RATIO);
    localparam int PW    = clog2_min1(PACKET_BEATS);

    if ((OUT_SIZE < 1) || (DATA_SIZE % OUT_SIZE != 0) || (PACKET_BEATS < 1)) begin : g_bad_params
        $error("axi4_stream_downsizer: DATA_SIZE must be a multiple of OUT_SIZE, PACKET_BEATS >= 1");
    end

    logic [RATIO-1:0][OUT_SIZE-1:0] hold;
    logic                           hold_valid;
    logic [SW-1:0]                  slice_cnt;
    logic                           slice_last;
    logic [PW-1:0]                  packet_cnt;
    logic                           packet_last;
    logic                           out_fire;
    logic                           in_fire;

    assign out_fire = hold_valid && write_data_ready;
    assign in_fire  = read_data_valid && read_data_ready;

    // Refill is allowed in the same cycle the final slice leaves, so no bubble.
    assign read_data_ready = resetn && (!hold_valid || (write_data_ready && slice_last));

    assign write_data       = hold[slice_cnt];
    assign write_data_valid = hold_valid;
    assign write_data_last  = hold_valid && packet_last;

    stream_wrap_counter #(
        .MAX (RATIO - 1)
    ) u_slice_cnt (
        .clk    (clk),
        .resetn (resetn),
        .en     (out_fire),
        .count  (slice_cnt),
        .at_max (slice_last)
    );

    stream_wrap_counter #(
        .MAX (PACKET_BEATS - 1)
    ) u_packet_cnt (
        .clk    (clk),
        .resetn (resetn),
        .en     (out_fire),
        .count  (packet_cnt),
        .at_max (packet_last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (in_fire) begin
            hold       <= read_data;
            hold_valid <= 1'b1;
        end else if (out_fire && slice_last) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4_stream_downsizer.sv
// Directed self-checking bench for axi4_stream_downsizer (RATIO 4, packets of 16 and 6).
module tb_axi4_stream_downsizer;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] rd;
    logic        rdv;
    logic        rdy;
    logic [7:0]  wd;
    logic        wv;
    logic        wl;
    logic        wdr;

    logic [31:0] rd6;
    logic        rdv6;
    logic        rdy6;
    logic [7:0]  wd6;
    logic        wv6;
    logic        wl6;
    logic        wdr6;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    axi4_stream_downsizer #(
        .DATA_SIZE    (32),
        .OUT_SIZE     (8),
        .PACKET_BEATS (16)
    ) u_dut (
        .clk              (clk),
        .resetn           (resetn),
        .read_data        (rd),
        .read_data_valid  (rdv),
        .read_data_ready  (rdy),
        .write_data       (wd),
        .write_data_valid (wv),
        .write_data_last  (wl),
        .write_data_ready (wdr)
    );

    axi4_stream_downsizer #(
        .DATA_SIZE    (32),
        .OUT_SIZE     (8),
        .PACKET_BEATS (6)
    ) u_p6 (
        .clk              (clk),
        .resetn           (resetn),
        .read_data        (rd6),
        .read_data_valid  (rdv6),
        .read_data_ready  (rdy6),
        .write_data       (wd6),
        .write_data_valid (wv6),
        .write_data_last  (wl6),
        .write_data_ready (wdr6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rdv    = 1'b0;
        rdv6   = 1'b0;
        resetn = 1'b0;
        repeat (n) tick();
        resetn = 1'b1;
        #1;
    endtask

    // Streams n words through u_dut with the sink always ready.
    task automatic seq_main(input logic [31:0] w [], input int n);
        logic [31:0] cur;
        wdr = 1'b1;
        rd  = w[0];
        rdv = 1'b1;
        #1;
        chk("seq_ready_empty", 32'(rdy), 32'd1);
        tick();
        for (int b = 0; b < n * 4; b++) begin
            cur = w[b / 4];
            chk("seq_data", 32'(wd), 32'(cur[8 * (b % 4) +: 8]));
            chk("seq_valid", 32'(wv), 32'd1);
            chk("seq_last", 32'(wl), 32'((b % 16) == 15));
            chk("seq_ready", 32'(rdy), 32'((b % 4) == 3));
            if ((b % 4) == 3 && (b / 4 + 1) < n) begin
                rd  = w[b / 4 + 1];
                rdv = 1'b1;
            end else begin
                rdv = 1'b0;
            end
            tick();
        end
        chk("seq_drained", 32'(wv), 32'd0);
    endtask

    initial begin
        logic [31:0] words [];
        int          in_i;
        int          out_i;
        int          cyc;
        bit          stalled;
        bit          pat [4];

        rd   = '0;
        rd6  = '0;
        wdr  = 1'b1;
        wdr6 = 1'b1;
        rdv  = 1'b0;
        rdv6 = 1'b0;
        resetn = 1'b0;
        tick();

        // 1: reset holds ready low even with valid asserted
        rdv    = 1'b1;
        resetn = 1'b0;
        repeat (3) tick();
        chk("rst_ready", 32'(rdy), 32'd0);
        chk("rst_valid", 32'(wv), 32'd0);
        chk("rst_last", 32'(wl), 32'd0);
        chk("rst_data", 32'(wd), 32'd0);
        rdv    = 1'b0;
        resetn = 1'b1;
        #1;

        // 2: single word
        words = new[1];
        words[0] = 32'hDDCCBBAA;
        seq_main(words, 1);

        // 3: back-to-back packet of 16 beats
        do_reset(2);
        words = new[4];
        words[0] = 32'h03020100;
        words[1] = 32'h07060504;
        words[2] = 32'h0B0A0908;
        words[3] = 32'h0F0E0D0C;
        seq_main(words, 4);

        // 4: backpressure over 64 words, bytes 0..255 in order
        do_reset(2);
        pat[0] = 1'b1;
        pat[1] = 1'b0;
        pat[2] = 1'b0;
        pat[3] = 1'b1;
        in_i    = 0;
        out_i   = 0;
        cyc     = 0;
        stalled = 1'b0;
        while (out_i < 256 && cyc < 3000) begin
            wdr = pat[(cyc * 5 + cyc / 3) % 4];
            rdv = (in_i < 64);
            for (int k = 0; k < 4; k++) rd[8 * k +: 8] = 8'(4 * in_i + k);
            @(negedge clk);
            if (stalled) chk("bp_valid_held", 32'(wv), 32'd1);
            if (wv) begin
                chk("bp_data", 32'(wd), 32'(out_i[7:0]));
                chk("bp_last", 32'(wl), 32'((out_i % 16) == 15));
            end
            stalled = wv && !wdr;
            if (wv && wdr) out_i++;
            if (rdv && rdy) in_i++;
            cyc++;
            tick();
        end
        chk("bp_out_count", 32'(out_i), 32'd256);
        chk("bp_in_count", 32'(in_i), 32'd64);
        rdv = 1'b0;
        #1;
        chk("bp_drained", 32'(wv), 32'd0);

        // 5: PACKET_BEATS=6, last falls mid-word
        do_reset(2);
        words = new[3];
        words[0] = 32'h03020100;
        words[1] = 32'h07060504;
        words[2] = 32'h0B0A0908;
        wdr6 = 1'b1;
        rd6  = words[0];
        rdv6 = 1'b1;
        tick();
        for (int b = 0; b < 12; b++) begin
            chk("p6_data", 32'(wd6), 32'(b));
            chk("p6_valid", 32'(wv6), 32'd1);
            chk("p6_last", 32'(wl6), 32'(b == 5 || b == 11));
            if ((b % 4) == 3 && (b / 4 + 1) < 3) begin
                rd6  = words[b / 4 + 1];
                rdv6 = 1'b1;
            end else begin
                rdv6 = 1'b0;
            end
            tick();
        end
        chk("p6_drained", 32'(wv6), 32'd0);

        // 6: reset mid-word discards remaining slices and packet count
        do_reset(2);
        wdr = 1'b1;
        rd  = 32'h44332211;
        rdv = 1'b1;
        tick();
        rdv = 1'b0;
        chk("mid_slice0", 32'(wd), 32'h11);
        tick();
        chk("mid_slice1", 32'(wd), 32'h22);
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        chk("mid_valid_after_rst", 32'(wv), 32'd0);
        chk("mid_ready_after_rst", 32'(rdy), 32'd1);
        words = new[4];
        words[0] = 32'h88776655;
        words[1] = 32'hCCBBAA99;
        words[2] = 32'h1100FFEE;
        words[3] = 32'h55443322;
        seq_main(words, 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
